serial_addsub: RTL

Bit-serial two's-complement adder/subtractor. It processes one bit pair per clock, LSB first, through a single full-add/full-subtract cell and one carry/borrow flip-flop. It complements the combinational half/full subtractor cells in the arithmetic practice set: it is the sequential datapath block those cells feed, and it supports both directions, A+B and A−B. A start/busy/done handshake connects it to a controlling FSM or testbench.

---
 rtl/serial_addsub.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor.
// One bit pair is processed per clock, LSB first. A single full-add/full-sub
// cell and one carry/borrow flop are shared by every bit.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      operation request, sampled only in IDLE
//   sub        0 = a+b, 1 = a-b (latched at accepted start)
//   a, b       operands (latched at accepted start)
//   busy       high while bits are being processed
//   done       one-cycle completion pulse
//   result     sum/difference, valid from done until the next accepted start
//   carry_out  add: final carry; sub: final borrow (a < b unsigned)
//   overflow   signed overflow of the operation
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// RUN   | one bit processed per cycle, LSB first
// DONE  | done pulse for one cycle, then back to IDLE

`timescale 1ns/1ps

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             c, mode, sa, sb;
  logic             x, y, sbit, c_n, last;

  assign x    = a_sh[0];
  assign y    = b_sh[0];
  assign sbit = x ^ y ^ c;
  // Add propagates a carry, subtract propagates a borrow.
  assign c_n  = mode ? ((~x & y) | (c & ~(x ^ y)))
                     : ((x & y) | (c & (x ^ y)));
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      mode   <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh   <= a;
          b_sh   <= b;
          res_sh <= '0;
          cnt    <= '0;
          c      <= 1'b0;
          mode   <= sub;
          sa     <= a[WIDTH-1];
          sb     <= b[WIDTH-1];
        end
        RUN: begin
          res_sh <= {sbit, res_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          c      <= c_n;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result    = res_sh;
  assign carry_out = c;
  // Sign-bit overflow rule; all-zero state after reset yields 0.
  assign overflow  = mode ? ((sa != sb) && (res_sh[WIDTH-1] != sa))
                          : ((sa == sb) && (res_sh[WIDTH-1] != sa));

endmodule
